sequencer_scheduler: RTL and testbench
======================================

# sequencer_scheduler

Tempo and step scheduler for sequencer mode. Generates the shared beat index (0..STEPS-1) that all per-step note players compare against. Selects the current step's note from the concatenated player bus, holds it for a gate (sustain) interval, then rests until the next beat. Handles start/pause and tempo selection, and sits between the button edge detectors and the waveform/divider stage.

## Interface
Parameters:
- STEPS, 8, number of steps per measure (2..16)
- TICKS_PER_BEAT, 2500, clk cycles per beat at tempo_sel=0 (10 kHz clk → 0.25 s), ≤ 65535
- SUSTAIN_TICKS, 2000, gate length in clk cycles at tempo_sel=0; must satisfy 1 ≤ SUSTAIN_TICKS < TICKS_PER_BEAT

Ports:
- clk  in  1  system clock (10 kHz)
- rst  in  1  synchronous, active-high reset
- sequencer_on  in  1  1 = sequencer mode, 0 = piano mode
- run_toggle  in  1  one-cycle edge-detected pulse; start/pause
- tempo_sel  in  2  tempo divisor: period = TICKS_PER_BEAT >> tempo_sel
- notes_in  in  4*STEPS  step i note code at bits [4i+3:4i]; 0 = OFF, 1..13 = lowC..highC
- beat  out  4  current step index, to players
- beat_strobe  out  1  one-cycle pulse on the first cycle of each beat
- note_out  out  4  scheduled note code; 0 when silent
- gate  out  1  1 when note_out ≠ 0
- running  out  1  1 in PLAY or REST

## Operation
- States: IDLE, PAUSE, PLAY, REST. All outputs are registered.
- Reset: state=IDLE, beat=0, tick=0, note_out=0, gate=0, beat_strobe=0, running=0, period/gate_len loaded from tempo_sel=0.
- Priority each cycle: rst > sequencer_on=0 > run_toggle > tick advance.
- sequencer_on=0 from any state → IDLE next cycle. beat, tick, note_out, gate and beat_strobe are cleared.
- IDLE & sequencer_on=1 → PAUSE. beat=0, tick=0.
- PAUSE & run_toggle → PLAY (if tick < gate_len) or REST. note_out latches notes_in[beat] on that edge. beat_strobe=1 only if tick=0.
- PLAY/REST & run_toggle → PAUSE. tick and beat freeze, note_out=0, gate=0. Any boundary or gate-end due that cycle is discarded.
- Running, tick < period-1: tick increments. In PLAY, when tick = gate_len-1, the next cycle is REST with note_out=0.
- Running, tick = period-1 (beat boundary), next cycle:
  - tick=0
  - beat=(beat+1) mod STEPS
  - beat_strobe=1
  - state=PLAY
  - note_out=notes_in[(beat+1) mod STEPS], sampled at that edge
  - period and gate_len reload from current tempo_sel
- tempo_sel is sampled only at beat boundaries and on PAUSE→run and IDLE→PAUSE transitions. A change mid-beat has no effect until the next boundary.
- gate_len = max(1, SUSTAIN_TICKS >> tempo_sel); period = max(2, TICKS_PER_BEAT >> tempo_sel). If gate_len ≥ period, gate_len is clamped to period-1.
- A latched note of 0 keeps the state timing unchanged; note_out=0 and gate=0 for the whole beat.
- notes_in changes mid-gate do not alter note_out. The value is latched once per beat.

## Timing
- Beat period is exactly `period` clk cycles. beat_strobe is high for exactly 1 cycle per beat while running.
- note_out is high for exactly gate_len cycles starting on the beat_strobe cycle, then 0 for period−gate_len cycles.
- Latency: run_toggle at edge N → running=1 and note_out valid at edge N+1. The same latency applies to pause.
- sequencer_on falling at edge N → all outputs 0 (beat=0) after edge N+1.
- Wrap: beat STEPS-1 → 0 with no extra cycle.
- A rst asserted mid-beat returns all outputs to their reset values on the next edge.

## Test plan
Bench uses STEPS=8, TICKS_PER_BEAT=8, SUSTAIN_TICKS=4, notes_in step i = i+1.
1. Reset, sequencer_on=1, run_toggle pulse → next cycle running=1, beat=0, beat_strobe=1, note_out=1 for 4 cycles, then 0 for 4 cycles; beat=1 and note_out=2 at cycle 8.
2. Run 64 cycles → beat sequence 0..7 then wraps to 0, with exactly 8 beat_strobe pulses spaced 8 cycles apart.
3. Pause at tick 2 of beat 3, hold 20 cycles, resume → outputs 0 while paused; after resume note_out=4 for 1 more cycle, then beat 4 starts 6 cycles after resume.
4. tempo_sel=1 changed mid-beat → current beat still 8 cycles; following beats are 4 cycles with a 2-cycle gate. tempo_sel=3 → period 2, gate 1.
5. Step 5 note set to 0 → beat 5 has beat_strobe=1, gate=0, note_out=0, and timing is unchanged.
6. sequencer_on=0 asserted in the same cycle as run_toggle at a beat boundary → IDLE, beat=0, note_out=0, running=0; rst mid-beat behaves the same.

Source files
------------

// File: rtl/sequencer_scheduler.sv
// Beat/step scheduler for sequencer mode: advances the shared beat index, latches each step's
// note for a gate interval, then rests until the next beat. All outputs are registered.
module sequencer_scheduler #(
  parameter int STEPS          = 8,
  parameter int TICKS_PER_BEAT = 2500,
  parameter int SUSTAIN_TICKS  = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sequencer_on,
  input  logic               run_toggle,
  input  logic [1:0]         tempo_sel,
  input  logic [4*STEPS-1:0] notes_in,
  output logic [3:0]         beat,
  output logic               beat_strobe,
  output logic [3:0]         note_out,
  output logic               gate,
  output logic               running
);

  typedef enum logic [1:0] {IDLE, PAUSE, PLAY, REST} state_t;

  localparam logic [15:0] TPB     = 16'(TICKS_PER_BEAT);
  localparam logic [15:0] SUS     = 16'(SUSTAIN_TICKS);
  localparam logic [15:0] PERIOD0 = (TPB < 16'd2) ? 16'd2 : TPB;
  localparam logic [15:0] GATE0   = (SUS == 16'd0) ? 16'd1 :
                                    (SUS >= PERIOD0) ? PERIOD0 - 16'd1 : SUS;

  state_t      state;
  logic [15:0] tick;
  logic [15:0] period;
  logic [15:0] gate_len;

  logic [15:0] tpb_shr;
  logic [15:0] sus_shr;
  logic [15:0] period_sel;
  logic [15:0] gate_sel;
  logic [3:0]  next_beat;
  logic [3:0]  cur_note;
  logic [3:0]  nxt_note;
  logic [3:0]  note_arr [16];

  // Tempo-scaled timing; gate is kept strictly shorter than the beat so a rest always follows.
  assign tpb_shr    = TPB >> tempo_sel;
  assign sus_shr    = SUS >> tempo_sel;
  assign period_sel = (tpb_shr < 16'd2) ? 16'd2 : tpb_shr;
  assign gate_sel   = (sus_shr == 16'd0) ? 16'd1 :
                      (sus_shr >= period_sel) ? period_sel - 16'd1 : sus_shr;

  for (genvar i = 0; i < 16; i++) begin : g_notes
    if (i < STEPS) begin : g_used
      assign note_arr[i] = notes_in[4*i +: 4];
    end else begin : g_unused
      assign note_arr[i] = 4'd0;
    end
  end

  assign next_beat = (beat == 4'(STEPS - 1)) ? 4'd0 : beat + 4'd1;
  assign cur_note  = note_arr[beat];
  assign nxt_note  = note_arr[next_beat];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= 4'd0;
      tick        <= 16'd0;
      note_out    <= 4'd0;
      gate        <= 1'b0;
      beat_strobe <= 1'b0;
      running     <= 1'b0;
      period      <= PERIOD0;
      gate_len    <= GATE0;
    end else if (!sequencer_on) begin
      state       <= IDLE;
      beat        <= 4'd0;
      tick        <= 16'd0;
      note_out    <= 4'd0;
      gate        <= 1'b0;
      beat_strobe <= 1'b0;
      running     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= PAUSE;
          beat        <= 4'd0;
          tick        <= 16'd0;
          period      <= period_sel;
          gate_len    <= gate_sel;
          note_out    <= 4'd0;
          gate        <= 1'b0;
          beat_strobe <= 1'b0;
          running     <= 1'b0;
        end
        PAUSE: begin
          if (run_toggle) begin
            period      <= period_sel;
            gate_len    <= gate_sel;
            running     <= 1'b1;
            beat_strobe <= (tick == 16'd0);
            // Resuming past the gate window lands directly in the rest phase.
            if (tick < gate_sel) begin
              state    <= PLAY;
              note_out <= cur_note;
              gate     <= (cur_note != 4'd0);
            end else begin
              state    <= REST;
              note_out <= 4'd0;
              gate     <= 1'b0;
            end
          end
        end
        PLAY, REST: begin
          if (run_toggle) begin
            state       <= PAUSE;
            note_out    <= 4'd0;
            gate        <= 1'b0;
            beat_strobe <= 1'b0;
            running     <= 1'b0;
          end else if (tick >= period - 16'd1) begin
            state       <= PLAY;
            tick        <= 16'd0;
            beat        <= next_beat;
            beat_strobe <= 1'b1;
            note_out    <= nxt_note;
            gate        <= (nxt_note != 4'd0);
            period      <= period_sel;
            gate_len    <= gate_sel;
          end else begin
            tick        <= tick + 16'd1;
            beat_strobe <= 1'b0;
            if (state == PLAY && tick == gate_len - 16'd1) begin
              state    <= REST;
              note_out <= 4'd0;
              gate     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer_scheduler.sv
// Directed bench for sequencer_scheduler with STEPS=8, 8-tick beats, 4-tick gate.
module tb_sequencer_scheduler;

  logic        clk;
  logic        rst;
  logic        sequencer_on;
  logic        run_toggle;
  logic [1:0]  tempo_sel;
  logic [31:0] notes_in;
  logic [3:0]  beat;
  logic        beat_strobe;
  logic [3:0]  note_out;
  logic        gate;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;

  sequencer_scheduler #(
    .STEPS(8),
    .TICKS_PER_BEAT(8),
    .SUSTAIN_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sequencer_on(sequencer_on),
    .run_toggle(run_toggle),
    .tempo_sel(tempo_sel),
    .notes_in(notes_in),
    .beat(beat),
    .beat_strobe(beat_strobe),
    .note_out(note_out),
    .gate(gate),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_beat"}, 32'(beat), 0);
    check({tag, "_note"}, 32'(note_out), 0);
    check({tag, "_gate"}, 32'(gate), 0);
    check({tag, "_strobe"}, 32'(beat_strobe), 0);
    check({tag, "_running"}, 32'(running), 0);
  endtask

  task automatic pulse_run();
    run_toggle = 1'b1;
    step();
    run_toggle = 1'b0;
  endtask

  initial begin
    int last;
    int cnt;
    int eb;
    rst          = 1'b1;
    sequencer_on = 1'b0;
    run_toggle   = 1'b0;
    tempo_sel    = 2'd0;
    notes_in     = 32'h8765_4321;
    step();
    step();
    check_zero("reset");

    // Start: IDLE -> PAUSE -> PLAY
    rst          = 1'b0;
    sequencer_on = 1'b1;
    step();
    check("pause_running", 32'(running), 0);
    pulse_run();
    check("start_running", 32'(running), 1);
    for (int c = 0; c < 8; c++) begin
      check("t1_beat", 32'(beat), 0);
      check("t1_note", 32'(note_out), (c < 4) ? 1 : 0);
      check("t1_gate", 32'(gate), (c < 4) ? 1 : 0);
      check("t1_strobe", 32'(beat_strobe), (c == 0) ? 1 : 0);
      step();
    end
    check("t1_beat1", 32'(beat), 1);
    check("t1_note2", 32'(note_out), 2);

    // 64 cycles: beats 1..7 then wrap to 0
    last = -1;
    cnt  = 0;
    for (int k = 0; k < 64; k++) begin
      eb = (1 + k / 8) % 8;
      check("t2_beat", 32'(beat), 32'(eb));
      check("t2_note", 32'(note_out), (k % 8 < 4) ? 32'(eb + 1) : 0);
      if (beat_strobe) begin
        if (last >= 0) check("t2_gap", 32'(k - last), 8);
        last = k;
        cnt++;
      end
      step();
    end
    check("t2_strobes", 32'(cnt), 8);

    // Pause at tick 2 of beat 3, hold, resume
    for (int k = 0; k < 18; k++) step();
    check("t3_pre_beat", 32'(beat), 3);
    check("t3_pre_note", 32'(note_out), 4);
    pulse_run();
    for (int k = 0; k < 20; k++) begin
      check("t3_hold_note", 32'(note_out), 0);
      check("t3_hold_run", 32'(running), 0);
      check("t3_hold_beat", 32'(beat), 3);
      step();
    end
    pulse_run();
    check("t3_res_note", 32'(note_out), 4);
    check("t3_res_strobe", 32'(beat_strobe), 0);
    check("t3_res_run", 32'(running), 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t3_beat", 32'(beat), (k < 6) ? 3 : 4);
      check("t3_note", 32'(note_out), (k == 1) ? 4 : (k < 6) ? 0 : 5);
    end
    check("t3_strobe", 32'(beat_strobe), 1);

    // Latched note survives notes_in change; silent step 5 keeps timing
    notes_in = 32'h8700_4321;
    step();
    check("t5_latched", 32'(note_out), 5);
    for (int k = 0; k < 7; k++) step();
    for (int c = 0; c < 8; c++) begin
      check("t5_beat", 32'(beat), 5);
      check("t5_note", 32'(note_out), 0);
      check("t5_gate", 32'(gate), 0);
      check("t5_strobe", 32'(beat_strobe), (c == 0) ? 1 : 0);
      step();
    end
    check("t5_next_beat", 32'(beat), 6);
    check("t5_next_note", 32'(note_out), 7);
    notes_in = 32'h8765_4321;

    // Tempo change mid-beat takes effect at the next boundary
    for (int k = 0; k < 3; k++) step();
    tempo_sel = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t4_cur_beat", 32'(beat), (k < 5) ? 6 : 7);
    end
    for (int c = 0; c < 4; c++) begin
      check("t4_fast_beat", 32'(beat), 7);
      check("t4_fast_note", 32'(note_out), (c < 2) ? 8 : 0);
      step();
    end
    check("t4_wrap_beat", 32'(beat), 0);
    check("t4_wrap_note", 32'(note_out), 1);
    check("t4_wrap_strobe", 32'(beat_strobe), 1);
    tempo_sel = 2'd3;
    for (int k = 0; k < 4; k++) step();
    check("t4_p2_beat", 32'(beat), 1);
    check("t4_p2_note", 32'(note_out), 2);
    check("t4_p2_strobe", 32'(beat_strobe), 1);
    step();
    check("t4_p2_rest_beat", 32'(beat), 1);
    check("t4_p2_rest_note", 32'(note_out), 0);
    step();
    check("t4_p2_next_beat", 32'(beat), 2);
    check("t4_p2_next_note", 32'(note_out), 3);

    // sequencer_on drop beats run_toggle at a boundary
    step();
    sequencer_on = 1'b0;
    run_toggle   = 1'b1;
    step();
    run_toggle   = 1'b0;
    check_zero("t6_off");

    // Restart, then rst mid-beat
    tempo_sel    = 2'd0;
    sequencer_on = 1'b1;
    step();
    pulse_run();
    check("t6_restart_note", 32'(note_out), 1);
    check("t6_restart_strobe", 32'(beat_strobe), 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("t6_rst");
    step();
    pulse_run();
    check("t6_after_rst_run", 32'(running), 1);
    check("t6_after_rst_note", 32'(note_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
